// File: rtl/vedic_pkg.sv
// Shared constants and state encoding for the Vedic multiplier/divider pair.
package vedic_pkg;
  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/urdhva_mult_16.sv
// Combinational 16x16 -> 32 unsigned Urdhva-Tiryagbhyam multiplier:
// each output column k is the vertical-crosswise count of a[i]&b[k-i], weighted by 2^k.
module urdhva_mult_16 import vedic_pkg::*; (
  input  logic [CHUNK_W-1:0]   a,
  input  logic [CHUNK_W-1:0]   b,
  output logic [2*CHUNK_W-1:0] p
);
  logic [4:0]           col [2*CHUNK_W-1];
  logic [2*CHUNK_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int k = 0; k < 2*CHUNK_W-1; k++) begin
      col[k] = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
        if ((k - i) >= 0 && (k - i) < CHUNK_W)
          col[k] = col[k] + 5'(a[i] & b[4'(k - i)]);
      end
      // Column counts overlap; carries ripple through the weighted add.
      sum = sum + ((2*CHUNK_W)'(col[k]) << k);
    end
  end

  assign p = sum;
endmodule

// File: rtl/vedic_seq_multiplier_16bit.sv
// Multi-cycle unsigned multiplier reusing one 16x16 Urdhva core over N*N chunk pairs.
// Define VEDIC_MUL_ADDEND_EN to add an addend port (product = A*B + addend).
module vedic_seq_multiplier_16bit import vedic_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef VEDIC_MUL_ADDEND_EN
  input  logic [WIDTH-1:0]   addend,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);
  localparam int N    = WIDTH / CHUNK_W;
  localparam int NN   = N * N;
  localparam int IDXW = (NN > 1) ? $clog2(NN) : 1;
  localparam int AW   = 2 * WIDTH;
  localparam logic [IDXW-1:0] LAST = IDXW'(NN - 1);

  mul_state_t      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d, product_q, product_d;

  logic [CHUNK_W-1:0]   core_a, core_b;
  logic [2*CHUNK_W-1:0] core_p;
  logic [AW-1:0]        partial;
  int                   ci, cj;

  urdhva_mult_16 u_core (.a(core_a), .b(core_b), .p(core_p));

  // idx walks row-major over (i, j) chunk pairs; partial lands at weight 16*(i+j).
  always_comb begin
    ci      = int'(idx_q) / N;
    cj      = int'(idx_q) % N;
    core_a  = a_q[ci*CHUNK_W +: CHUNK_W];
    core_b  = b_q[cj*CHUNK_W +: CHUNK_W];
    partial = AW'(core_p) << (CHUNK_W * (ci + cj));
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = multiplicand;
        b_d     = multiplier;
`ifdef VEDIC_MUL_ADDEND_EN
        acc_d   = AW'(addend);
`else
        acc_d   = '0;
`endif
        idx_d   = '0;
        state_d = CALC;
      end
      CALC: begin
        acc_d = acc_q + partial;
        if (idx_q == LAST) begin
          product_d = acc_d;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;
  assign done    = (state_q == DONE);
  assign busy    = (state_q != IDLE);
endmodule
